// File: rtl/panic_cell_alloc_if.sv
// Allocation request/grant, cell-return handshake and status bundle for panic_cell_alloc.
// slave = allocator side, master = requester/environment side.
interface panic_cell_alloc_if #(
  parameter int unsigned NUM_REQ       = 2,
  parameter int unsigned CELL_ID_WIDTH = 16,
  parameter int unsigned LEN_WIDTH     = 16
);
  logic [NUM_REQ-1:0]           alloc_mem_req;
  logic [NUM_REQ*LEN_WIDTH-1:0] alloc_mem_size;
  logic [NUM_REQ-1:0]           alloc_grant;
  logic [NUM_REQ-1:0]           alloc_mem_success;
  logic [CELL_ID_WIDTH-1:0]     alloc_cell_id;
  logic                         alloc_port_id;
  logic                         alloc_mem_intense;
  logic                         free_valid;
  logic                         free_ready;
  logic [CELL_ID_WIDTH-1:0]     free_cell_id;
  logic                         free_port_id;
  logic                         init_done;
  logic                         err_overflow;
  logic [31:0]                  stat_alloc_cnt;
  logic [31:0]                  stat_fail_cnt;

  modport slave (
    input  alloc_mem_req, alloc_mem_size, free_valid, free_cell_id, free_port_id,
    output alloc_grant, alloc_mem_success, alloc_cell_id, alloc_port_id, alloc_mem_intense,
           free_ready, init_done, err_overflow, stat_alloc_cnt, stat_fail_cnt
  );

  modport master (
    output alloc_mem_req, alloc_mem_size, free_valid, free_cell_id, free_port_id,
    input  alloc_grant, alloc_mem_success, alloc_cell_id, alloc_port_id, alloc_mem_intense,
           free_ready, init_done, err_overflow, stat_alloc_cnt, stat_fail_cnt
  );
endinterface

// File: rtl/panic_cell_alloc.sv
// Two-port cell free-list allocator with round-robin requester arbitration.
// Statistics counters are built only when PANIC_ALLOC_STATS_EN is defined.
module panic_cell_alloc #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned CELL_ID_WIDTH  = 16,
  parameter int unsigned LEN_WIDTH      = 16,
  parameter int unsigned CELL_ADDR_BITS = 8,
  parameter int unsigned CELL_BYTES     = 2048,
  parameter int unsigned INTENSE_THRESH = 16
) (
  input logic               clk,
  input logic               rst_n,
  panic_cell_alloc_if.slave bus
);
  localparam int unsigned NCELL = 1 << CELL_ADDR_BITS;
  localparam int unsigned CW    = CELL_ADDR_BITS + 1;
  localparam int unsigned RRW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                    r_state, w_state_nxt;
  logic [CELL_ADDR_BITS-1:0] r_init_idx;
  logic [CELL_ADDR_BITS-1:0] r_mem  [2][NCELL];
  logic [CELL_ADDR_BITS-1:0] r_head [2];
  logic [CELL_ADDR_BITS-1:0] r_tail [2];
  logic [CW-1:0]             r_cnt  [2];
  logic [RRW-1:0]            r_rr;
  logic                      r_ovf;

  logic                      w_run, w_init_last;
  logic                      w_found, w_grant_v, w_size_ok, w_ok;
  logic [RRW-1:0]            w_gidx;
  logic [NUM_REQ-1:0]        w_grant;
  logic [LEN_WIDTH-1:0]      w_size;
  logic                      w_sel, w_pp, w_full, w_push, w_push_ok, w_ovf;
  logic [1:0]                w_pop_p, w_push_p;
  logic [CELL_ADDR_BITS-1:0] w_head;
  logic [CW:0]               w_total;
  logic                      w_unused_id;

  always_comb begin : fsm
    w_state_nxt = r_state;
    w_run       = 1'b0;
    w_init_last = 1'b0;
    case (r_state)
      S_INIT: begin
        w_init_last = (r_init_idx == CELL_ADDR_BITS'(NCELL - 1));
        if (w_init_last) w_state_nxt = S_RUN;
      end
      S_RUN:   w_run = 1'b1;
      default: w_state_nxt = S_INIT;
    endcase
  end

  // Search starts at r_rr and wraps; the first asserted request wins.
  always_comb begin : arb
    logic [RRW-1:0] idx;
    w_found = 1'b0;
    w_gidx  = '0;
    idx     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = RRW'((32'(r_rr) + k) % NUM_REQ);
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (!w_found && (RRW'(j) == idx) && bus.alloc_mem_req[j]) begin
          w_found = 1'b1;
          w_gidx  = idx;
        end
      end
    end
  end

  always_comb begin : grant_dec
    w_grant = '0;
    w_size  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (RRW'(k) == w_gidx) begin
        w_grant[k] = w_grant_v;
        w_size     = bus.alloc_mem_size[k*LEN_WIDTH +: LEN_WIDTH];
      end
    end
  end

  assign w_grant_v = w_run && w_found;
  assign w_size_ok = (w_size != '0) && (32'(w_size) <= CELL_BYTES);
  assign w_sel     = (r_cnt[1] > r_cnt[0]);
  assign w_head    = r_mem[w_sel][r_head[w_sel]];
  assign w_ok      = w_grant_v && (r_cnt[w_sel] != '0) && w_size_ok;
  assign w_pop_p   = {w_ok && w_sel, w_ok && !w_sel};

  // A full list still accepts a push when the same cycle pops it.
  assign w_pp      = bus.free_port_id;
  assign w_push    = w_run && bus.free_valid;
  assign w_full    = (r_cnt[w_pp] == CW'(NCELL));
  assign w_push_ok = w_push && (!w_full || w_pop_p[w_pp]);
  assign w_ovf     = w_push && !w_push_ok;
  assign w_push_p  = {w_push_ok && w_pp, w_push_ok && !w_pp};

  assign w_total     = {1'b0, r_cnt[0]} + {1'b0, r_cnt[1]};
  assign w_unused_id = ^bus.free_cell_id;

  always_ff @(posedge clk) begin
    if (r_state == S_INIT) begin
      r_mem[0][r_init_idx] <= r_init_idx;
      r_mem[1][r_init_idx] <= r_init_idx;
    end else if (w_push_ok) begin
      r_mem[w_pp][r_tail[w_pp]] <= bus.free_cell_id[CELL_ADDR_BITS-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_INIT;
      r_init_idx <= '0;
      r_rr       <= '0;
      r_ovf      <= 1'b0;
      for (int unsigned p = 0; p < 2; p++) begin
        r_head[p] <= '0;
        r_tail[p] <= '0;
        r_cnt[p]  <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_INIT) r_init_idx <= r_init_idx + 1'b1;
      if (w_ok) r_rr <= RRW'((32'(w_gidx) + 1) % NUM_REQ);
      if (w_ovf) r_ovf <= 1'b1;
      for (int unsigned p = 0; p < 2; p++) begin
        if (w_init_last) r_cnt[p] <= CW'(NCELL);
        if (w_pop_p[p])  r_head[p] <= r_head[p] + 1'b1;
        if (w_push_p[p]) r_tail[p] <= r_tail[p] + 1'b1;
        if (w_pop_p[p] && !w_push_p[p])      r_cnt[p] <= r_cnt[p] - 1'b1;
        else if (w_push_p[p] && !w_pop_p[p]) r_cnt[p] <= r_cnt[p] + 1'b1;
      end
    end
  end

  assign bus.alloc_grant       = w_grant;
  assign bus.alloc_mem_success = w_grant & {NUM_REQ{w_ok}};
  assign bus.alloc_cell_id     = w_grant_v ? CELL_ID_WIDTH'(w_head) : '0;
  assign bus.alloc_port_id     = w_grant_v & w_sel;
  assign bus.alloc_mem_intense = (32'(w_total) < INTENSE_THRESH);
  assign bus.free_ready        = w_run;
  assign bus.init_done         = w_run;
  assign bus.err_overflow      = r_ovf;

`ifdef PANIC_ALLOC_STATS_EN
  logic [31:0] r_stat_alloc, r_stat_fail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_alloc <= '0;
      r_stat_fail  <= '0;
    end else begin
      if (w_ok && (r_stat_alloc != '1)) r_stat_alloc <= r_stat_alloc + 1'b1;
      if (w_grant_v && !w_ok && (r_stat_fail != '1)) r_stat_fail <= r_stat_fail + 1'b1;
    end
  end

  assign bus.stat_alloc_cnt = r_stat_alloc;
  assign bus.stat_fail_cnt  = r_stat_fail;
`else
  assign bus.stat_alloc_cnt = '0;
  assign bus.stat_fail_cnt  = '0;
`endif
endmodule

// File: tb/tb_panic_cell_alloc.sv
// Self-checking bench for panic_cell_alloc: directed vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_panic_cell_alloc;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  panic_cell_alloc_if #(.NUM_REQ(2), .CELL_ID_WIDTH(16), .LEN_WIDTH(16)) bus ();

  panic_cell_alloc #(
    .NUM_REQ(2), .CELL_ID_WIDTH(16), .LEN_WIDTH(16), .CELL_ADDR_BITS(8),
    .CELL_BYTES(2048), .INTENSE_THRESH(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: one queue of free cell IDs per memory port.
  int     q0[$];
  int     q1[$];
  int     m_rr, m_g, m_cell;
  logic   m_sel, m_ok, m_ovf, m_intense;
  logic [1:0] m_grant_vec, m_succ_vec;
  longint m_alloc, m_fail;

  typedef struct {
    logic [1:0]  req;
    logic [15:0] s0, s1;
    logic        fv;
    logic [15:0] fcid;
    logic        fp;
    logic [1:0]  eg, es;
    logic [15:0] ecell;
    logic        eport;
  } vec_t;
  vec_t tbl[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] req, input logic [15:0] s0, input logic [15:0] s1,
                       input logic fv, input logic [15:0] fcid, input logic fp);
    bus.alloc_mem_req  = req;
    bus.alloc_mem_size = {s1, s0};
    bus.free_valid     = fv;
    bus.free_cell_id   = fcid;
    bus.free_port_id   = fp;
  endtask

  task automatic model_init();
    q0.delete();
    q1.delete();
    for (int i = 0; i < 256; i++) begin
      q0.push_back(i);
      q1.push_back(i);
    end
    m_rr = 0; m_ovf = 1'b0; m_alloc = 0; m_fail = 0;
  endtask

  task automatic model_eval();
    int sz, avail;
    m_g = -1;
    for (int k = 0; k < 2; k++) begin
      int i;
      i = (m_rr + k) % 2;
      if (m_g < 0 && bus.alloc_mem_req[i]) m_g = i;
    end
    m_sel  = (q1.size() > q0.size());
    avail  = m_sel ? q1.size() : q0.size();
    m_cell = (avail == 0) ? 0 : (m_sel ? q1[0] : q0[0]);
    sz     = (m_g < 0) ? 0 : int'(bus.alloc_mem_size[m_g*16 +: 16]);
    m_ok   = (m_g >= 0) && (avail > 0) && (sz >= 1) && (sz <= 2048);
    m_grant_vec = (m_g < 0) ? 2'b00 : (2'b01 << m_g);
    m_succ_vec  = m_ok ? m_grant_vec : 2'b00;
    m_intense   = (q0.size() + q1.size()) < 16;
  endtask

  task automatic model_commit();
    if (m_ok) begin
      if (m_sel) void'(q1.pop_front());
      else       void'(q0.pop_front());
      m_rr = (m_g + 1) % 2;
      m_alloc++;
    end else if (m_g >= 0) begin
      m_fail++;
    end
    if (bus.free_valid) begin
      int id;
      id = int'(bus.free_cell_id) % 256;
      if (bus.free_port_id) begin
        if (q1.size() == 256) m_ovf = 1'b1; else q1.push_back(id);
      end else begin
        if (q0.size() == 256) m_ovf = 1'b1; else q0.push_back(id);
      end
    end
  endtask

  task automatic check_model();
    chk("grant", bus.alloc_grant, m_grant_vec);
    chk("success", bus.alloc_mem_success, m_succ_vec);
    if (m_ok) begin
      chk("cell_id", bus.alloc_cell_id, m_cell);
      chk("port_id", bus.alloc_port_id, m_sel);
    end
    chk("intense", bus.alloc_mem_intense, m_intense);
    chk("free_ready", bus.free_ready, 1'b1);
    chk("err_overflow", bus.err_overflow, m_ovf);
    chk("init_done", bus.init_done, 1'b1);
`ifdef PANIC_ALLOC_STATS_EN
    chk("stat_alloc", bus.stat_alloc_cnt, m_alloc);
    chk("stat_fail", bus.stat_fail_cnt, m_fail);
`else
    chk("stat_alloc", bus.stat_alloc_cnt, 0);
    chk("stat_fail", bus.stat_fail_cnt, 0);
`endif
  endtask

  task automatic run_cycle(input logic [1:0] req, input logic [15:0] s0, input logic [15:0] s1,
                           input logic fv, input logic [15:0] fcid, input logic fp);
    drive(req, s0, s1, fv, fcid, fp);
    #3;
    model_eval();
    check_model();
  endtask

  task automatic end_cycle();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic init_seq();
    int   n;
    logic bad;
    rst_n = 1'b0;
    drive(2'b11, 16'd64, 16'd64, 1'b1, 16'd5, 1'b1);
    @(posedge clk);
    #1;
    chk("rst_grant", bus.alloc_grant, 0);
    chk("rst_success", bus.alloc_mem_success, 0);
    chk("rst_cell", bus.alloc_cell_id, 0);
    chk("rst_port", bus.alloc_port_id, 0);
    chk("rst_free_ready", bus.free_ready, 0);
    chk("rst_init_done", bus.init_done, 0);
    chk("rst_err", bus.err_overflow, 0);
    chk("rst_intense", bus.alloc_mem_intense, 1);
    chk("rst_stat_alloc", bus.stat_alloc_cnt, 0);
    chk("rst_stat_fail", bus.stat_fail_cnt, 0);
    rst_n = 1'b1;
    n = 0;
    bad = 1'b0;
    while (!bus.init_done && n < 400) begin
      if (bus.alloc_grant != 0 || bus.alloc_mem_success != 0 || bus.free_ready) bad = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    chk("init_latency", n, 256);
    chk("init_quiet", bad, 0);
    drive(2'b00, 16'd0, 16'd0, 1'b0, 16'd0, 1'b0);
    model_init();
  endtask

  function automatic logic [15:0] rnd_size();
    int unsigned r;
    r = $urandom_range(0, 7);
    if (r == 0) return 16'd0;
    if (r == 1) return 16'(2049 + $urandom_range(0, 3000));
    return 16'(1 + $urandom_range(0, 2047));
  endfunction

  initial begin
    int   guard, tot_at;
    logic seen;

    tbl[0]  = '{2'b01, 16'd64,   16'd0,    1'b0, 16'd0, 1'b0, 2'b01, 2'b01, 16'd0, 1'b0};
    tbl[1]  = '{2'b11, 16'd1500, 16'd1500, 1'b0, 16'd0, 1'b0, 2'b10, 2'b10, 16'd0, 1'b1};
    tbl[2]  = '{2'b11, 16'd1500, 16'd1500, 1'b0, 16'd0, 1'b0, 2'b01, 2'b01, 16'd1, 1'b0};
    tbl[3]  = '{2'b11, 16'd1500, 16'd1500, 1'b0, 16'd0, 1'b0, 2'b10, 2'b10, 16'd1, 1'b1};
    tbl[4]  = '{2'b11, 16'd1500, 16'd1500, 1'b0, 16'd0, 1'b0, 2'b01, 2'b01, 16'd2, 1'b0};
    tbl[5]  = '{2'b01, 16'd0,    16'd0,    1'b0, 16'd0, 1'b0, 2'b01, 2'b00, 16'd0, 1'b0};
    tbl[6]  = '{2'b01, 16'd2049, 16'd0,    1'b0, 16'd0, 1'b0, 2'b01, 2'b00, 16'd0, 1'b0};
    tbl[7]  = '{2'b01, 16'd2048, 16'd0,    1'b0, 16'd0, 1'b0, 2'b01, 2'b01, 16'd2, 1'b1};
    tbl[8]  = '{2'b10, 16'd0,    16'd1,    1'b0, 16'd0, 1'b0, 2'b10, 2'b10, 16'd3, 1'b0};
    tbl[9]  = '{2'b00, 16'd0,    16'd0,    1'b1, 16'd3, 1'b0, 2'b00, 2'b00, 16'd0, 1'b0};
    tbl[10] = '{2'b11, 16'd2048, 16'd2048, 1'b0, 16'd0, 1'b0, 2'b01, 2'b01, 16'd4, 1'b0};
    tbl[11] = '{2'b10, 16'd0,    16'd2049, 1'b0, 16'd0, 1'b0, 2'b10, 2'b00, 16'd0, 1'b0};
    tbl[12] = '{2'b11, 16'd100,  16'd2049, 1'b0, 16'd0, 1'b0, 2'b10, 2'b00, 16'd0, 1'b0};

    drive(2'b00, 16'd0, 16'd0, 1'b0, 16'd0, 1'b0);
    init_seq();
    chk("post_init_intense", bus.alloc_mem_intense, 0);

    // Directed vector table
    for (int i = 0; i < 13; i++) begin
      run_cycle(tbl[i].req, tbl[i].s0, tbl[i].s1, tbl[i].fv, tbl[i].fcid, tbl[i].fp);
      chk($sformatf("tbl%0d_grant", i), bus.alloc_grant, tbl[i].eg);
      chk($sformatf("tbl%0d_success", i), bus.alloc_mem_success, tbl[i].es);
      if (tbl[i].es != 2'b00) begin
        chk($sformatf("tbl%0d_cell", i), bus.alloc_cell_id, tbl[i].ecell);
        chk($sformatf("tbl%0d_port", i), bus.alloc_port_id, tbl[i].eport);
      end
      end_cycle();
    end

    // Random traffic: drain-leaning then fill-leaning free rate
    for (int c = 0; c < 3000; c++) begin
      int unsigned thr;
      thr = (c < 1500) ? 1 : 3;
      run_cycle(2'($urandom_range(0, 3)), rnd_size(), rnd_size(),
                ($urandom_range(0, 3) < thr), 16'($urandom_range(0, 65535)),
                1'($urandom_range(0, 1)));
      end_cycle();
    end

    // Reset asserted in the middle of a request cycle
    run_cycle(2'b01, 16'd64, 16'd0, 1'b0, 16'd0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_grant", bus.alloc_grant, 0);
    chk("midrst_success", bus.alloc_mem_success, 0);
    chk("midrst_cell", bus.alloc_cell_id, 0);
    chk("midrst_free_ready", bus.free_ready, 0);
    chk("midrst_init_done", bus.init_done, 0);
    chk("midrst_err", bus.err_overflow, 0);
    chk("midrst_intense", bus.alloc_mem_intense, 1);
    init_seq();

    // Overflow on a full list, then pop+push on the same list
    run_cycle(2'b00, 16'd0, 16'd0, 1'b1, 16'd5, 1'b1);
    end_cycle();
    run_cycle(2'b01, 16'd64, 16'd0, 1'b1, 16'd9, 1'b0);
    chk("ovf_sticky", bus.err_overflow, 1);
    chk("reissue_success", bus.alloc_mem_success, 2'b01);
    chk("reissue_cell", bus.alloc_cell_id, 0);
    chk("reissue_port", bus.alloc_port_id, 0);
    end_cycle();
    run_cycle(2'b01, 16'd64, 16'd0, 1'b0, 16'd0, 1'b0);
    chk("popush_cell", bus.alloc_cell_id, 1);
    chk("popush_port", bus.alloc_port_id, 0);
    end_cycle();

    // Exhaust every cell, watching the pressure flag
    guard = 0;
    seen = 1'b0;
    tot_at = -1;
    while ((q0.size() + q1.size()) > 0 && guard < 700) begin
      run_cycle(2'b01, 16'd100, 16'd0, 1'b0, 16'd0, 1'b0);
      if (!seen && bus.alloc_mem_intense) begin
        seen = 1'b1;
        tot_at = q0.size() + q1.size();
      end
      end_cycle();
      guard++;
    end
    chk("intense_rise_total", tot_at, 15);
    run_cycle(2'b01, 16'd100, 16'd0, 1'b0, 16'd0, 1'b0);
    chk("empty_alloc_success", bus.alloc_mem_success, 0);
    chk("empty_alloc_grant", bus.alloc_grant, 2'b01);
    end_cycle();
    run_cycle(2'b00, 16'd0, 16'd0, 1'b1, 16'd7, 1'b1);
    end_cycle();
    run_cycle(2'b01, 16'd100, 16'd0, 1'b0, 16'd0, 1'b0);
    chk("refree_success", bus.alloc_mem_success, 2'b01);
    chk("refree_cell", bus.alloc_cell_id, 7);
    chk("refree_port", bus.alloc_port_id, 1);
    end_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/panic_cell_alloc.md
PANIC_CELL_ALLOC -- requirements
Module: panic_cell_alloc

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of parser requesters sharing the allocator.
REQ-002 SHALL have parameter CELL_ID_WIDTH, default 16, width of returned cell ID.
REQ-003 SHALL have parameter LEN_WIDTH, default 16, width of request size.
REQ-004 SHALL have parameter CELL_ADDR_BITS, default 8, log2 of cells per memory port (256 cells per port, 2 ports).
REQ-005 SHALL have parameter CELL_BYTES, default 2048, maximum bytes one cell holds.
REQ-006 SHALL have parameter INTENSE_THRESH, default 16, total-free level below which pressure is flagged.
REQ-007 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-008 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port alloc_mem_req, input, NUM_REQ, per-requester allocation request (level, combinational response).
REQ-010 SHALL have port alloc_mem_size, input, NUM_REQ*LEN_WIDTH, per-requester packet length in bytes, requester i at bits [i*LEN_WIDTH +: LEN_WIDTH].
REQ-011 SHALL have port alloc_grant, output, NUM_REQ, one-hot arbitration grant this cycle.
REQ-012 SHALL have port alloc_mem_success, output, NUM_REQ, allocation completed for requester i this cycle.
REQ-013 SHALL have port alloc_cell_id, output, CELL_ID_WIDTH, cell granted (shared; valid only with a success bit).
REQ-014 SHALL have port alloc_port_id, output, 1, memory port of the granted cell.
REQ-015 SHALL have port alloc_mem_intense, output, 1, total free cells < INTENSE_THRESH.
REQ-016 SHALL have ports free_valid input 1, free_ready output 1, free_cell_id input CELL_ID_WIDTH, free_port_id input 1: cell return handshake.
REQ-017 SHALL have ports init_done output 1 (free lists populated) and err_overflow output 1 (sticky, free to a full list).
REQ-018 SHALL have ports stat_alloc_cnt and stat_fail_cnt, output, 32 each, statistics counters.

Function
REQ-019 SHALL keep one FIFO free list per memory port, depth 2^CELL_ADDR_BITS, plus per-port free counters of width CELL_ADDR_BITS+1.
REQ-020 SHALL run FSM INIT -> RUN; INIT writes cell IDs 0..2^CELL_ADDR_BITS-1 into both lists one per cycle, enters RUN after the last write, then init_done=1.
REQ-021 SHALL, in INIT, hold alloc_grant, alloc_mem_success and free_ready at 0.
REQ-022 SHALL grant round-robin among asserted alloc_mem_req bits, starting search at the index after the last successful requester; pointer advances only on success.
REQ-023 SHALL select the port with the larger free count; tie selects port 0.
REQ-024 SHALL assert alloc_mem_success[g] combinationally in the same cycle as the grant iff selected port count != 0 and 0 < size[g] <= CELL_BYTES.
REQ-025 SHALL drive alloc_cell_id as the selected list head, zero-extended, and alloc_port_id as the selected port, in the same cycle.
REQ-026 SHALL pop the selected list on the clock edge ending a success cycle; a new head is presented the next cycle.
REQ-027 SHALL, on a failed grant (no cells or bad size), not pop and not move the RR pointer.
REQ-028 SHALL hold free_ready=1 in RUN; on free_valid&&free_ready push free_cell_id[CELL_ADDR_BITS-1:0] into list free_port_id.
REQ-029 SHALL, on simultaneous pop and push to the same list, perform both; count unchanged.
REQ-030 SHALL, on push to a full list, drop the entry and set err_overflow until reset.
REQ-031 SHALL compute alloc_mem_intense combinationally from the registered counts.

Reset
REQ-032 SHALL, on rst_n low (asynchronous, any time incl. mid-allocation), return to INIT with counts 0, RR pointer 0, init_done 0, err_overflow 0, stats 0, list contents discarded.
REQ-033 SHALL hold all outputs at 0 during reset except alloc_mem_intense=1.

Configuration
REQ-034 SHALL, with PANIC_ALLOC_STATS_EN defined, increment stat_alloc_cnt per success and stat_fail_cnt per failed grant, both saturating at 2^32-1.
REQ-035 SHALL, without PANIC_ALLOC_STATS_EN, tie both stat outputs to 0 and omit the counter logic.

Verification
REQ-036 Release reset, no traffic -> init_done rises 256 cycles after INIT entry; alloc_mem_intense 0; first req0 size 64 -> success[0]=1, cell 0, port 0.
REQ-037 req0 and req1 held continuously, size 1500 -> grants alternate 0,1,0,1; ports alternate 0,1; cells 0,0,1,1.
REQ-038 req0 size 0, then 2049 -> grant[0]=1, success=0, no pop, stat_fail_cnt +2 (STATS_EN).
REQ-039 allocate all 512 cells -> intense rises when total free reaches 15; 513th request fails; free cell 7 port 1 -> next grant returns cell 7, port 1.
REQ-040 free to a full list after init -> err_overflow=1, counts unchanged; same-cycle alloc and free on port 0 -> count unchanged.
REQ-041 assert rst_n low mid-success cycle -> outputs 0 immediately, INIT restarts, cell 0 reissued after init_done.
